// File: rtl/fifo_enq_arbiter.sv
// Round-robin arbiter sharing one FIFO enqueue port among NREQ requesters,
// with per-requester accepted-transfer counters and a sticky protocol-error flag.
module fifo_enq_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 96,
  parameter int CNTW  = 16
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [NREQ-1:0]         req_want,
  input  logic [NREQ-1:0]         req_enq__ENA,
  input  logic [NREQ*WIDTH-1:0]   req_enq_v,
  output logic [NREQ-1:0]         req_enq__RDY,
  output logic                    out_enq__ENA,
  output logic [WIDTH-1:0]        out_enq_v,
  input  logic                    out_enq__RDY,
  output logic [NREQ*CNTW-1:0]    stat_count,
  output logic                    stat_err,
  input  logic                    stat_clear__ENA
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   r_ptr;
  logic [CNTW-1:0] r_count [NREQ];
  logic            r_err;

  logic [NREQ-1:0] w_gnt;
  logic [NREQ-1:0] w_fire;
  logic            w_fire_any;
  logic            w_err_set;
  logic [PW-1:0]   w_ptr_nxt;

  // Grant depends only on want, ptr and FIFO ready so requesters may
  // legally derive ENA from RDY without forming a loop.
  always_comb begin : grant_search
    logic v_found;
    int   v_idx;
    w_gnt   = '0;
    v_found = 1'b0;
    v_idx   = 0;
    for (int j = 0; j < NREQ; j++) begin
      v_idx = (int'(r_ptr) + j) % NREQ;
      if (!v_found && req_want[v_idx]) begin
        w_gnt[v_idx] = 1'b1;
        v_found      = 1'b1;
      end
    end
  end

  assign req_enq__RDY = w_gnt & {NREQ{out_enq__RDY}};
  assign w_fire       = req_enq__ENA & req_enq__RDY;
  assign w_fire_any   = |w_fire;
  assign w_err_set    = |(req_enq__ENA & ~req_enq__RDY);
  assign out_enq__ENA = w_fire_any;

  // At most one fire bit is set, so the last match is the only match.
  always_comb begin : fire_mux
    w_ptr_nxt = '0;
    out_enq_v = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_fire[i]) begin
        w_ptr_nxt = PW'((i + 1) % NREQ);
        out_enq_v = req_enq_v[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_ptr <= '0;
      r_err <= 1'b0;
      for (int i = 0; i < NREQ; i++) r_count[i] <= '0;
    end else begin
      if (w_fire_any) r_ptr <= w_ptr_nxt;
      // Clear wins over a same-cycle increment or error capture.
      if (stat_clear__ENA)  r_err <= 1'b0;
      else if (w_err_set)   r_err <= 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (stat_clear__ENA)  r_count[i] <= '0;
        else if (w_fire[i])   r_count[i] <= r_count[i] + CNTW'(1);
      end
    end
  end

  always_comb begin : count_pack
    stat_count = '0;
    for (int i = 0; i < NREQ; i++) stat_count[i*CNTW +: CNTW] = r_count[i];
  end

  assign stat_err = r_err;

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Bench for fifo_enq_arbiter: directed vector table, hand sequences for
// multi-cycle corners, randomized traffic against a behavioural model.
module tb_fifo_enq_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 96;
  localparam int CNTW  = 16;

  logic                  clk;
  logic                  n_rst;
  logic [NREQ-1:0]       req_want;
  logic [NREQ-1:0]       req_ena;
  logic [NREQ*WIDTH-1:0] req_v;
  logic [NREQ-1:0]       req_rdy;
  logic                  out_ena;
  logic [WIDTH-1:0]      out_v;
  logic                  out_rdy;
  logic [NREQ*CNTW-1:0]  stat_count;
  logic                  stat_err;
  logic                  stat_clear;

  fifo_enq_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .CLK             (clk),
    .nRST            (n_rst),
    .req_want        (req_want),
    .req_enq__ENA    (req_ena),
    .req_enq_v       (req_v),
    .req_enq__RDY    (req_rdy),
    .out_enq__ENA    (out_ena),
    .out_enq_v       (out_v),
    .out_enq__RDY    (out_rdy),
    .stat_count      (stat_count),
    .stat_err        (stat_err),
    .stat_clear__ENA (stat_clear)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: priority pointer, counters, sticky error
  int              m_ptr;
  logic [CNTW-1:0] m_cnt [NREQ];
  bit              m_err;

  // scoreboard
  logic [WIDTH-1:0] exp_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] model_gnt(input logic [NREQ-1:0] want);
    for (int j = 0; j < NREQ; j++) begin
      int k;
      k = (m_ptr + j) % NREQ;
      if (want[k]) return NREQ'(1) << k;
    end
    return '0;
  endfunction

  function automatic void model_reset();
    m_ptr = 0;
    m_err = 0;
    for (int i = 0; i < NREQ; i++) m_cnt[i] = '0;
  endfunction

  // One cycle: drive at posedge+1, check combinational outputs, clock, check state.
  task automatic step(input logic [NREQ-1:0] want, input logic [NREQ-1:0] ena,
                      input logic frdy, input logic clr, input logic rst,
                      output logic [NREQ-1:0] o_rdy, output logic o_oena);
    logic [NREQ-1:0] e_rdy;
    logic [NREQ-1:0] e_fire;
    int k;
    req_want   = want;
    req_ena    = ena;
    out_rdy    = frdy;
    stat_clear = clr;
    n_rst      = ~rst;
    for (int i = 0; i < NREQ; i++) req_v[i*WIDTH +: WIDTH] = {$urandom, $urandom, $urandom};
    #1;
    e_rdy  = model_gnt(want) & {NREQ{frdy}};
    e_fire = ena & e_rdy;
    k = -1;
    for (int i = 0; i < NREQ; i++) if (e_fire[i]) begin
      k = i;
      exp_q.push_back(req_v[i*WIDTH +: WIDTH]);
    end
    o_rdy  = req_rdy;
    o_oena = out_ena;
    check("rdy", 128'(req_rdy), 128'(e_rdy));
    check("out_ena", 128'(out_ena), 128'(e_fire != 0));
    if (out_ena) begin
      if (exp_q.size() == 0) check("out_v_unexpected", 128'(out_v), 128'(0) - 1);
      else check("out_v", 128'(out_v), 128'(exp_q.pop_front()));
    end else begin
      check("out_v_idle", 128'(out_v), 128'(0));
    end
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (k >= 0) begin
        m_ptr    = (k + 1) % NREQ;
        m_cnt[k] = m_cnt[k] + 1'b1;
      end
      if ((ena & ~e_rdy) != 0) m_err = 1;
      if (clr) begin
        m_err = 0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = '0;
      end
    end
    #1;
    for (int i = 0; i < NREQ; i++) check($sformatf("count[%0d]", i), 128'(stat_count[i*CNTW +: CNTW]), 128'(m_cnt[i]));
    check("err", 128'(stat_err), 128'(m_err));
  endtask

  typedef struct {
    logic [NREQ-1:0] want;
    logic [NREQ-1:0] ena;
    logic            frdy;
    logic [NREQ-1:0] exp_rdy;
    logic            exp_oena;
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [NREQ-1:0] r;
    logic o;
    // Starts at ptr=0: round-robin through all four, then ptr=2 corner, then full FIFO.
    vecs[0] = '{4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b1};
    vecs[1] = '{4'b1111, 4'b0010, 1'b1, 4'b0010, 1'b1};
    vecs[2] = '{4'b1111, 4'b0100, 1'b1, 4'b0100, 1'b1};
    vecs[3] = '{4'b1111, 4'b1000, 1'b1, 4'b1000, 1'b1};
    vecs[4] = '{4'b1111, 4'b0001, 1'b1, 4'b0001, 1'b1};
    vecs[5] = '{4'b1111, 4'b0010, 1'b1, 4'b0010, 1'b1};
    vecs[6] = '{4'b1011, 4'b1000, 1'b1, 4'b1000, 1'b1};
    vecs[7] = '{4'b1011, 4'b0000, 1'b1, 4'b0001, 1'b0};
    vecs[8] = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0};

    req_want = '0; req_ena = '0; req_v = '0; out_rdy = 1'b1; stat_clear = 1'b0; n_rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // reset state checks (still in reset)
    step(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, r, o);
    check("reset_rdy", 128'(r), 128'(4'b0001));
    check("reset_counts", 128'(stat_count), 128'(0));

    // directed table
    for (int v = 0; v < 9; v++) begin
      step(vecs[v].want, vecs[v].ena, vecs[v].frdy, 1'b0, 1'b0, r, o);
      check($sformatf("vec%0d_rdy", v), 128'(r), 128'(vecs[v].exp_rdy));
      check($sformatf("vec%0d_oena", v), 128'(o), 128'(vecs[v].exp_oena));
    end
    check("tbl_count0", 128'(stat_count[0 +: CNTW]), 128'(2));
    check("tbl_count3", 128'(stat_count[3*CNTW +: CNTW]), 128'(2));

    // FIFO full for 5 cycles with eager requesters
    repeat (5) begin
      step(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, r, o);
      check("full_rdy", 128'(r), 128'(0));
    end

    // illegal ENA from requester 2 while only requester 0 is granted
    step(4'b0001, 4'b0100, 1'b1, 1'b0, 1'b0, r, o);
    check("illegal_rdy", 128'(r), 128'(4'b0001));
    check("illegal_oena", 128'(o), 128'(0));
    check("illegal_err", 128'(stat_err), 128'(1));
    check("illegal_count2", 128'(stat_count[2*CNTW +: CNTW]), 128'(1));
    step(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, r, o);
    check("clear_err", 128'(stat_err), 128'(0));
    check("clear_counts", 128'(stat_count), 128'(0));

    // grant held without ENA does not rotate
    step(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, r, o);
    repeat (3) begin
      step(4'b0011, 4'b0000, 1'b1, 1'b0, 1'b0, r, o);
      check("hold_rdy", 128'(r), 128'(4'b0010));
    end
    step(4'b0011, 4'b0010, 1'b1, 1'b0, 1'b0, r, o);
    check("hold_count1", 128'(stat_count[CNTW +: CNTW]), 128'(1));
    step(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, r, o);
    check("hold_ptr2", 128'(r), 128'(4'b0100));

    // clear and fire in the same cycle: clear wins
    step(4'b0100, 4'b0100, 1'b1, 1'b1, 1'b0, r, o);
    check("clear_prio", 128'(stat_count), 128'(0));

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      logic [NREQ-1:0] w, e;
      logic fr, cl;
      w  = NREQ'($urandom_range(0, 15));
      fr = ($urandom_range(0, 9) < 8);
      cl = ($urandom_range(0, 19) == 0);
      e  = ($urandom_range(0, 9) == 0) ? NREQ'($urandom_range(0, 15))
         : (($urandom_range(0, 3) != 0) ? (model_gnt(w) & {NREQ{fr}}) : '0);
      step(w, e, fr, cl, 1'b0, r, o);
    end

    // reset asserted during a legal fire: state dropped
    step(4'b1111, model_gnt(4'b1111), 1'b1, 1'b0, 1'b1, r, o);
    check("midrst_counts", 128'(stat_count), 128'(0));
    step(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, r, o);
    check("midrst_ptr", 128'(r), 128'(4'b0001));

    // counter wrap on requester 0
    for (int c = 0; c < 65535; c++) step(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, r, o);
    check("wrap_pre", 128'(stat_count[0 +: CNTW]), 128'(16'hFFFF));
    step(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, r, o);
    check("wrap_post", 128'(stat_count[0 +: CNTW]), 128'(0));
    check("wrap_noerr", 128'(stat_err), 128'(0));

    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
